// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback path.
// Used by regfile_wb_arbiter and its round-robin arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int REG_DATA_W     = 32;
  localparam int CONFLICT_CNT_W = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, scan starts at the pointer.
// The pointer moves past the winner; it holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Pick the first valid requester at or after the pointer.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && en && rst_n &&
          req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        ptr_nxt = PW'((int'(ptr) + k + 1) % N);
        found   = 1'b1;
      end
    end
  end

  // Advance the pointer past the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources.
// Optional REGFILE_WB_FWD_EN adds write-to-read forwarding outputs.
import regfile_pkg::*;

module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_W-1:0]     req_reg,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_reg,
  output logic [DATA_W-1:0]          wr_data,
  output logic [CONFLICT_CNT_W-1:0]  conflict_cnt
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]          rd_reg1,
  input  logic [ADDR_W-1:0]          rd_reg2,
  input  logic [DATA_W-1:0]          rf_data1,
  input  logic [DATA_W-1:0]          rf_data2,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2
`endif
);

  logic [NREQ-1:0]   grant;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              multi;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~hold),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign multi     = |(req_valid & (req_valid - 1'b1));

  // One-hot mux of the granted request's index and data.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_reg  = sel_reg  | req_reg[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register the write port; $zero writes load but never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else if (any_grant) begin
      wr_en   <= (sel_reg != ADDR_W'(REG_ZERO));
      wr_reg  <= sel_reg;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Saturating count of cycles with two or more requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (multi && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // Bypass the pending write onto matching read ports.
  always_comb begin
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
    if (wr_en && (wr_reg == rd_reg1) &&
        (rd_reg1 != ADDR_W'(REG_ZERO))) begin
      fwd_data1 = wr_data;
    end
    if (wr_en && (wr_reg == rd_reg2) &&
        (rd_reg2 != ADDR_W'(REG_ZERO))) begin
      fwd_data2 = wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed vectors.
// Forwarding checks are built when REGFILE_WB_FWD_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_reg;
  logic [DW-1:0]   wr_data;
  logic [15:0]     conflict_cnt;
`ifdef REGFILE_WB_FWD_EN
  logic [AW-1:0]   rd_reg1;
  logic [AW-1:0]   rd_reg2;
  logic [DW-1:0]   rf_data1;
  logic [DW-1:0]   rf_data2;
  logic [DW-1:0]   fwd_data1;
  logic [DW-1:0]   fwd_data2;
`endif

  int n_chk;
  int n_fail;

  regfile_wb_arbiter #(
    .NREQ   (N),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_en        (wr_en),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .conflict_cnt (conflict_cnt)
`ifdef REGFILE_WB_FWD_EN
    ,
    .rd_reg1      (rd_reg1),
    .rd_reg2      (rd_reg2),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [AW-1:0] r,
                         input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_reg[i*AW +: AW]   = r;
    req_data[i*DW +: DW]  = d;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] exp_g [6];
  logic [AW-1:0] exp_r [6];

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
`ifdef REGFILE_WB_FWD_EN
    rd_reg1  = '0;
    rd_reg2  = '0;
    rf_data1 = '0;
    rf_data2 = '0;
`endif

    // Reset state, ready masked even with requests present
    req_valid = 3'b111;
    #3;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_reg", 64'(wr_reg), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    #9;
    rst_n = 1'b1;
    cyc();

    // 1: single request from requester 1
    set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    chk("t1_ready", 64'(req_ready), 64'b010);
    cyc();
    req_valid = '0;
    chk("t1_wr_en", 64'(wr_en), 64'd1);
    chk("t1_wr_reg", 64'(wr_reg), 64'd7);
    chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    cyc();
    chk("t1_wr_en_off", 64'(wr_en), 64'd0);
    chk("t1_wr_reg_keep", 64'(wr_reg), 64'd7);
    chk("t1_cnt", 64'(conflict_cnt), 64'd0);

    // Pointer is 2: grant requester 2 alone to wrap it to 0
    set_req(2, 1'b1, 5'd3, 32'h33);
    #1;
    chk("wrap_ready", 64'(req_ready), 64'b100);
    cyc();
    chk("wrap_wr_reg", 64'(wr_reg), 64'd3);

    // 2: all three valid for 6 cycles
    set_req(0, 1'b1, 5'd1, 32'h100);
    set_req(1, 1'b1, 5'd2, 32'h200);
    set_req(2, 1'b1, 5'd3, 32'h300);
    exp_g = '{3'b001, 3'b010, 3'b100,
              3'b001, 3'b010, 3'b100};
    exp_r = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("t2_ready%0d", c),
          64'(req_ready), 64'(exp_g[c]));
      cyc();
      chk($sformatf("t2_wr_en%0d", c), 64'(wr_en), 64'd1);
      chk($sformatf("t2_wr_reg%0d", c),
          64'(wr_reg), 64'(exp_r[c]));
      chk($sformatf("t2_wr_data%0d", c),
          64'(wr_data), 64'(exp_r[c]) << 8);
      chk($sformatf("t2_cnt%0d", c),
          64'(conflict_cnt), 64'(c + 1));
    end
    req_valid = '0;

    // 3: write to $zero is consumed but not enabled
    set_req(0, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("t3_ready", 64'(req_ready), 64'b001);
    cyc();
    req_valid = '0;
    chk("t3_wr_en", 64'(wr_en), 64'd0);
    chk("t3_wr_reg", 64'(wr_reg), 64'd0);
    chk("t3_wr_data", 64'(wr_data), 64'h1234);
    chk("t3_cnt", 64'(conflict_cnt), 64'd6);

    // Pointer moved to 1
    set_req(0, 1'b1, 5'd1, 32'h100);
    set_req(1, 1'b1, 5'd2, 32'h200);
    set_req(2, 1'b1, 5'd3, 32'h300);
    #1;
    chk("t3_ptr", 64'(req_ready), 64'b010);
    cyc();
    chk("t3_wr_reg2", 64'(wr_reg), 64'd2);

    // 4: hold for 3 cycles, pending write still completes
    hold = 1'b1;
    #1;
    chk("t4_ready0", 64'(req_ready), 64'd0);
    chk("t4_pend", 64'(wr_en), 64'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        #1;
        chk($sformatf("t4_ready%0d", c),
            64'(req_ready), 64'd0);
      end
      cyc();
      chk($sformatf("t4_wr_en%0d", c), 64'(wr_en), 64'd0);
    end
    chk("t4_cnt", 64'(conflict_cnt), 64'd10);
    hold = 1'b0;
    #1;
    chk("t4_resume", 64'(req_ready), 64'b100);
    cyc();
    chk("t4_wr_en", 64'(wr_en), 64'd1);
    chk("t4_wr_reg", 64'(wr_reg), 64'd3);
    chk("t4_cnt2", 64'(conflict_cnt), 64'd11);

    // 5: reset mid-burst with a pending write
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_wr_en", 64'(wr_en), 64'd0);
    chk("t5_cnt", 64'(conflict_cnt), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t5_first", 64'(req_ready), 64'b001);
    cyc();
    req_valid = '0;
    chk("t5_wr_reg", 64'(wr_reg), 64'd1);

`ifdef REGFILE_WB_FWD_EN
    // 6: forwarding of the pending write
    set_req(1, 1'b1, 5'd9, 32'hA5A5A5A5);
    rd_reg1  = 5'd9;
    rd_reg2  = 5'd0;
    rf_data1 = '0;
    rf_data2 = '0;
    #1;
    chk("t6_ready", 64'(req_ready), 64'b010);
    cyc();
    req_valid = '0;
    #1;
    chk("t6_fwd1", 64'(fwd_data1), 64'hA5A5A5A5);
    chk("t6_fwd2", 64'(fwd_data2), 64'd0);
    rf_data1 = 32'h55;
    cyc();
    chk("t6_fwd1_idle", 64'(fwd_data1), 64'h55);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
